// File: rtl/bit_stream_pkg.sv
// Shared types and default constants for the bit-stream serializer.
// The PARITY state exists only when SERIALIZER_PARITY_EN is defined.
package bit_stream_pkg;

  localparam int unsigned DEF_WIDTH      = 8;
  localparam bit          DEF_MSB_FIRST  = 1'b1;
  localparam bit          DEF_IDLE_LEVEL = 1'b0;
  localparam int unsigned DEF_GAP_CYCLES = 0;

  localparam int unsigned GAP_W   = 8;
  localparam int unsigned COUNT_W = 16;

`ifdef SERIALIZER_PARITY_EN
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2,
    GAP    = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd3
  } state_t;
`endif

endpackage

// File: rtl/bit_stream_serializer.sv
// Parallel-to-serial converter with optional even parity (SERIALIZER_PARITY_EN)
// and a configurable idle gap after each word.
module bit_stream_serializer
  import bit_stream_pkg::*;
#(
  parameter int unsigned WIDTH      = DEF_WIDTH,
  parameter bit          MSB_FIRST  = DEF_MSB_FIRST,
  parameter bit          IDLE_LEVEL = DEF_IDLE_LEVEL,
  parameter int unsigned GAP_CYCLES = DEF_GAP_CYCLES
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [WIDTH-1:0]   data_in,
  input  logic               data_valid,
  output logic               data_ready,
  output logic               bit_out,
  output logic               bit_valid,
  output logic               busy,
  output logic [COUNT_W-1:0] words_sent
);

  localparam int unsigned      CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);
  localparam bit               GAP_EN   = (GAP_CYCLES != 0);
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYCLES - 1);

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     shift_q;
  logic [CNT_W-1:0]     bit_cnt_q;
  logic [GAP_W-1:0]     gap_cnt_q;
  logic [COUNT_W-1:0]   words_q;
  logic                 bit_out_q;
  logic                 bit_valid_q;
`ifdef SERIALIZER_PARITY_EN
  logic                 parity_q;
`endif

  logic                 last_data_c;
  logic                 final_bit_c;
  logic                 load_c;
  logic                 first_bit_c;
  logic                 next_bit_c;
  logic [WIDTH-1:0]     load_shift_c;
  logic [WIDTH-1:0]     step_shift_c;

  // shift_q always holds the bits not yet presented, aligned so the next one
  // sits at the output end of the register
  always_comb begin
    if (MSB_FIRST) begin
      first_bit_c  = data_in[WIDTH-1];
      next_bit_c   = shift_q[WIDTH-1];
      load_shift_c = {data_in[WIDTH-2:0], 1'b0};
      step_shift_c = {shift_q[WIDTH-2:0], 1'b0};
    end else begin
      first_bit_c  = data_in[0];
      next_bit_c   = shift_q[0];
      load_shift_c = {1'b0, data_in[WIDTH-1:1]};
      step_shift_c = {1'b0, shift_q[WIDTH-1:1]};
    end
  end

  // State register
  always_ff @(posedge clock) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next state and combinational handshake
  always_comb begin
    state_d     = state_q;
    data_ready  = 1'b0;
    last_data_c = (state_q == SHIFT) && (bit_cnt_q == LAST_IDX);
`ifdef SERIALIZER_PARITY_EN
    final_bit_c = (state_q == PARITY);
`else
    final_bit_c = last_data_c;
`endif

    if (!reset) begin
      if (state_q == IDLE)                 data_ready = 1'b1;
      else if (final_bit_c && !GAP_EN)     data_ready = 1'b1;
    end
    load_c = data_valid && data_ready;

    case (state_q)
      IDLE: begin
        if (load_c) state_d = SHIFT;
      end
      SHIFT: begin
        if (last_data_c) begin
`ifdef SERIALIZER_PARITY_EN
          state_d = PARITY;
`else
          if (load_c)      state_d = SHIFT;
          else if (GAP_EN) state_d = GAP;
          else             state_d = IDLE;
`endif
        end
      end
`ifdef SERIALIZER_PARITY_EN
      PARITY: begin
        if (load_c)      state_d = SHIFT;
        else if (GAP_EN) state_d = GAP;
        else             state_d = IDLE;
      end
`endif
      GAP: begin
        if (gap_cnt_q == '0) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Serial datapath, gap timer and word counter
  always_ff @(posedge clock) begin
    if (reset) begin
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      gap_cnt_q   <= '0;
      words_q     <= '0;
      bit_out_q   <= IDLE_LEVEL;
      bit_valid_q <= 1'b0;
`ifdef SERIALIZER_PARITY_EN
      parity_q    <= 1'b0;
`endif
    end else begin
      bit_out_q   <= IDLE_LEVEL;
      bit_valid_q <= 1'b0;

      if (load_c) begin
        shift_q     <= load_shift_c;
        bit_cnt_q   <= '0;
        bit_out_q   <= first_bit_c;
        bit_valid_q <= 1'b1;
`ifdef SERIALIZER_PARITY_EN
        parity_q    <= ^data_in;
`endif
      end else if ((state_q == SHIFT) && !last_data_c) begin
        shift_q     <= step_shift_c;
        bit_cnt_q   <= bit_cnt_q + CNT_W'(1);
        bit_out_q   <= next_bit_c;
        bit_valid_q <= 1'b1;
      end
`ifdef SERIALIZER_PARITY_EN
      else if (last_data_c) begin
        bit_out_q   <= parity_q;
        bit_valid_q <= 1'b1;
      end
`endif

      if (final_bit_c && !load_c) gap_cnt_q <= GAP_LOAD;
      else if (state_q == GAP)    gap_cnt_q <= gap_cnt_q - GAP_W'(1);

      if (final_bit_c) words_q <= words_q + COUNT_W'(1);
    end
  end

  assign bit_out    = bit_out_q;
  assign bit_valid  = bit_valid_q;
  assign busy       = (state_q != IDLE);
  assign words_sent = words_q;

endmodule
